// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - EX/MEM memory access stall, bubble and branch-flush controller
// Holds the pipeline while a load/store waits for MemAck, with a bounded wait and sticky timeout flag.

module mem_stall_ctrl #(
    parameter logic [4:0] LOAD_OP  = 5'd7,
    parameter logic [4:0] STORE_OP = 5'd8,
    parameter int         TIMEOUT  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ExMemOpCode,
    input  logic [6:0] ExMemAddress,
    input  logic       ExMemValid,
    input  logic       MemAck,
    input  logic       BranchTaken,
    output logic       MemReq,
    output logic       MemWrite,
    output logic [6:0] MemAddr,
    output logic       PipeEn,
    output logic       FlushIFID,
    output logic       FlushIDEX,
    output logic       BubbleMEMWB,
    output logic [1:0] State,
    output logic       TimeoutErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic       r_pending;
    logic       r_mem_req;
    logic       r_mem_write;
    logic [6:0] r_mem_addr;
    logic       r_timeout_err;

    logic       w_mem_op;
    logic       w_last;
    logic       w_pipe_en;
    logic       w_bubble;
    logic       w_latch;
    logic       w_timeout;
    logic       w_flush;

    assign w_mem_op = ExMemValid &
                      ((ExMemOpCode == LOAD_OP) | (ExMemOpCode == STORE_OP));
    assign w_last   = (r_cnt == LAST_WAIT);

    always_comb begin
        w_next_state = r_state;
        w_pipe_en    = 1'b1;
        w_bubble     = 1'b0;
        w_latch      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pipe_en = ~w_mem_op;
                if (w_mem_op) begin
                    w_next_state = ST_REQ;
                    w_latch      = 1'b1;
                end
            end
            ST_REQ: begin
                w_pipe_en = 1'b0;
                w_bubble  = 1'b1;
                // An ack on the final wait cycle still counts as success.
                if (MemAck) begin
                    w_next_state = ST_DONE;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                    w_timeout    = 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (rst) begin
            w_next_state = ST_IDLE;
            w_pipe_en    = 1'b1;
            w_bubble     = 1'b0;
            w_latch      = 1'b0;
            w_timeout    = 1'b0;
        end
    end

    // A branch seen while stalled is replayed as a flush in the DONE cycle.
    assign w_flush = ~rst & ((BranchTaken & w_pipe_en) |
                             ((r_state == ST_DONE) & r_pending));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_pending     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= 7'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_mem_req <= (w_next_state == ST_REQ);
            if (w_latch) begin
                r_mem_addr  <= ExMemAddress;
                r_mem_write <= (ExMemOpCode == STORE_OP);
                r_cnt       <= 4'd0;
            end else if ((r_state == ST_REQ) && !MemAck && !w_last) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_pending <= 1'b0;
            end else if (BranchTaken && !w_pipe_en) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign MemReq      = r_mem_req & ~rst;
    assign MemWrite    = r_mem_write;
    assign MemAddr     = r_mem_addr;
    assign PipeEn      = w_pipe_en;
    assign FlushIFID   = w_flush;
    assign FlushIDEX   = w_flush;
    assign BubbleMEMWB = w_bubble;
    assign State       = r_state;
    assign TimeoutErr  = r_timeout_err;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - directed and randomized bench for mem_stall_ctrl
// Outputs are compared every cycle against a transaction-level model of the access.

module tb_mem_stall_ctrl;

    localparam int TIMEOUT = 8;

    logic       clk;
    logic       rst;
    logic [4:0] op;
    logic [6:0] addr;
    logic       valid;
    logic       ack;
    logic       br;
    logic       mem_req;
    logic       mem_write;
    logic [6:0] mem_addr;
    logic       pipe_en;
    logic       flush_ifid;
    logic       flush_idex;
    logic       bubble;
    logic [1:0] state;
    logic       terr;

    mem_stall_ctrl #(.LOAD_OP(5'd7), .STORE_OP(5'd8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ExMemOpCode(op), .ExMemAddress(addr), .ExMemValid(valid),
        .MemAck(ack), .BranchTaken(br),
        .MemReq(mem_req), .MemWrite(mem_write), .MemAddr(mem_addr),
        .PipeEn(pipe_en), .FlushIFID(flush_ifid), .FlushIDEX(flush_idex),
        .BubbleMEMWB(bubble), .State(state), .TimeoutErr(terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cycle   = 0;

    // Model: an access is "in flight" for m_waited cycles, then a single done cycle follows.
    bit       m_active;
    int       m_waited;
    bit       m_done;
    bit [6:0] m_addr;
    bit       m_write;
    bit       m_pending;
    bit       m_terr;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
    endtask

    task automatic model_reset();
        m_active = 0; m_waited = 0; m_done = 0;
        m_addr = 0; m_write = 0; m_pending = 0; m_terr = 0;
    endtask

    // Called just after a rising edge: drive, check combinational view, advance model at edge.
    task automatic step(input bit v, input bit [4:0] o, input bit [6:0] a,
                        input bit k, input bit b, input bit r);
        bit memop, e_pipe, e_req, e_flush;
        bit [1:0] e_state;
        valid = v; op = o; addr = a; ack = k; br = b; rst = r;
        #3;
        memop   = v && (o == 5'd7 || o == 5'd8);
        e_state = m_active ? 2'd1 : (m_done ? 2'd2 : 2'd0);
        if (r)             e_pipe = 1;
        else if (m_active) e_pipe = 0;
        else if (m_done)   e_pipe = 1;
        else               e_pipe = !memop;
        e_req   = !r && m_active;
        e_flush = !r && ((b && e_pipe) || (m_done && m_pending));
        check("PipeEn",      8'(pipe_en),    8'(e_pipe));
        check("MemReq",      8'(mem_req),    8'(e_req));
        check("BubbleMEMWB", 8'(bubble),     8'(e_req));
        check("FlushIFID",   8'(flush_ifid), 8'(e_flush));
        check("FlushIDEX",   8'(flush_idex), 8'(e_flush));
        check("State",       8'(state),      8'(e_state));
        check("MemAddr",     8'(mem_addr),   8'(m_addr));
        check("MemWrite",    8'(mem_write),  8'(m_write));
        check("TimeoutErr",  8'(terr),       8'(m_terr));
        @(posedge clk);
        cycle++;
        if (r) begin
            model_reset();
        end else if (m_active) begin
            m_waited++;
            if (b) m_pending = 1;
            if (k) begin
                m_active = 0; m_done = 1;
            end else if (m_waited == TIMEOUT) begin
                m_active = 0; m_done = 1; m_terr = 1;
            end
        end else if (m_done) begin
            m_done = 0; m_pending = 0;
        end else if (memop) begin
            m_active = 1; m_waited = 0; m_addr = a; m_write = (o == 5'd8);
            if (b) m_pending = 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 7'd0, 0, 0, 0);
    endtask

    initial begin
        bit [4:0] ro;
        rst = 1; valid = 0; op = 0; addr = 0; ack = 0; br = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step(0, 5'd0, 7'd0, 0, 0, 1);
        idle(2);

        // Load acked on the third request cycle.
        step(1, 5'd7, 7'd9, 0, 0, 0);
        step(1, 5'd7, 7'd9, 0, 0, 0);
        step(1, 5'd7, 7'd9, 0, 0, 0);
        step(1, 5'd7, 7'd9, 1, 0, 0);
        step(0, 5'd0, 7'd0, 0, 0, 0);
        idle(2);

        // Non-memory ops and an invalid load never stall.
        step(1, 5'd3,  7'd1, 0, 0, 0);
        step(1, 5'd11, 7'd2, 1, 0, 0);
        step(0, 5'd7,  7'd3, 0, 0, 0);
        step(0, 5'd8,  7'd4, 1, 0, 0);

        // Branch in idle, then branch during a stall replayed in DONE.
        step(0, 5'd0, 7'd0, 0, 1, 0);
        step(1, 5'd7, 7'd20, 0, 0, 0);
        step(1, 5'd7, 7'd20, 0, 1, 0);
        step(1, 5'd7, 7'd20, 0, 0, 0);
        step(1, 5'd7, 7'd20, 1, 0, 0);
        step(0, 5'd0, 7'd0, 0, 0, 0);
        idle(2);

        // Ack on the final permitted wait cycle.
        step(1, 5'd8, 7'd33, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1, 5'd8, 7'd33, 0, 0, 0);
        step(1, 5'd8, 7'd33, 1, 0, 0);
        idle(3);

        // Store with no ack: timeout sets the sticky flag.
        step(1, 5'd8, 7'd6, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 5'd0, 7'd0, 0, 0, 0);
        idle(2);
        step(1, 5'd7, 7'd5, 0, 0, 0);
        step(0, 5'd0, 7'd0, 1, 0, 0);
        idle(2);

        // Reset during the second request cycle, pending flush discarded.
        step(1, 5'd7, 7'd44, 0, 0, 0);
        step(1, 5'd7, 7'd44, 0, 1, 0);
        step(1, 5'd7, 7'd44, 0, 0, 1);
        step(0, 5'd0, 7'd0, 0, 0, 0);
        step(1, 5'd7, 7'd45, 0, 0, 0);
        step(0, 5'd0, 7'd0, 0, 0, 0);
        step(0, 5'd0, 7'd0, 1, 0, 0);
        idle(2);

        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0: ro = 5'd7;
                1: ro = 5'd8;
                2: ro = 5'd3;
                default: ro = 5'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, ro, 7'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter LOAD_OP, default 5'd7: EX/MEM opcode for a memory read.
REQ-002 Parameter STORE_OP, default 5'd8: EX/MEM opcode for a memory write.
REQ-003 Parameter TIMEOUT, default 8, legal 1..15: max cycles to wait for MemAck.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ExMemOpCode  in  5  opcode held in EX/MEM register.
REQ-007 ExMemAddress  in  7  address held in EX/MEM register.
REQ-008 ExMemValid  in  1  EX/MEM register holds a real instruction.
REQ-009 MemAck  in  1  memory completion, one-cycle pulse.
REQ-010 BranchTaken  in  1  EX-stage branch resolved taken.
REQ-011 MemReq  out  1  memory request, level, held until ack or timeout.
REQ-012 MemWrite  out  1  1 = store, 0 = load; valid while MemReq=1.
REQ-013 MemAddr  out  7  latched access address.
REQ-014 PipeEn  out  1  load enable for IF/ID, ID/EX, EX/MEM registers.
REQ-015 FlushIFID  out  1  clear IF/ID this cycle.
REQ-016 FlushIDEX  out  1  clear ID/EX this cycle.
REQ-017 BubbleMEMWB  out  1  load NOP into MEM/WB this cycle.
REQ-018 State  out  2  FSM state: 0=IDLE, 1=REQ, 2=DONE; 3 unused.
REQ-019 TimeoutErr  out  1  sticky timeout flag.

Function
REQ-020 MemOp = ExMemValid & (ExMemOpCode==LOAD_OP | ExMemOpCode==STORE_OP).
REQ-021 IDLE: PipeEn = ~MemOp (same cycle); MemReq=0; BubbleMEMWB=0.
REQ-022 IDLE with MemOp: next state REQ; latch MemAddr<=ExMemAddress, MemWrite<=(opcode==STORE_OP); wait counter<=0.
REQ-023 REQ: MemReq=1, PipeEn=0, BubbleMEMWB=1; MemAck in same cycle -> DONE next edge.
REQ-024 REQ without MemAck: counter increments; when counter==TIMEOUT-1 and no ack, next state DONE and TimeoutErr<=1.
REQ-025 MemAck and timeout in same cycle: ack wins, TimeoutErr unchanged.
REQ-026 Request latency: MemReq rises exactly one cycle after MemOp first seen in IDLE; MemReq high for 1..TIMEOUT cycles.
REQ-027 DONE: exactly one cycle; PipeEn=1, MemReq=0, BubbleMEMWB=0; next state IDLE unconditionally.
REQ-028 MemAck in IDLE or DONE ignored.
REQ-029 MemAddr/MemWrite hold from latch through DONE; change only on next REQ-022 latch.
REQ-030 BranchTaken while PipeEn=1: FlushIFID=FlushIDEX=1 same cycle.
REQ-031 BranchTaken while PipeEn=0: set pending-flush flag; no flush that cycle.
REQ-032 DONE with pending flag: FlushIFID=FlushIDEX=1 that cycle; flag cleared.
REQ-033 Flush outputs zero in all other cycles.
REQ-034 TimeoutErr stays 1 until rst; further timeouts no effect.
REQ-035 State=3 unreachable; if entered, next state IDLE.

Reset
REQ-036 rst high at edge: State<=IDLE, MemReq<=0, MemWrite<=0, MemAddr<=0, counter<=0, pending<=0, TimeoutErr<=0.
REQ-037 While rst high: PipeEn=1, FlushIFID=FlushIDEX=0, BubbleMEMWB=0, MemReq=0.
REQ-038 rst in REQ aborts access: MemReq low the following cycle, no DONE cycle, pending flush discarded.

Verification
REQ-039 Load, ack after 3 cycles: Valid=1, Op=7, Addr=7'd9 -> PipeEn=0 at T0, MemReq=1 T1..T3, MemAddr=9, MemWrite=0, DONE at T4 with PipeEn=1, IDLE at T5.
REQ-040 Store, no ack, TIMEOUT=8: Op=8, Addr=7'd6 -> MemReq=1 for 8 cycles, MemWrite=1, DONE, TimeoutErr=1 and stays 1 across following ops.
REQ-041 Non-memory ops (Op=3, 11) with Valid=1, plus Op=7 with Valid=0 -> PipeEn=1 every cycle, MemReq never asserted.
REQ-042 BranchTaken pulse in IDLE -> flushes same cycle; pulse during REQ -> no flush until DONE cycle, then both flushes=1 for exactly one cycle.
REQ-043 rst asserted on second REQ cycle -> State=0, MemReq=0 next cycle, no flush, TimeoutErr=0; subsequent load completes normally.
REQ-044 MemAck coincident with counter==TIMEOUT-1 -> DONE, TimeoutErr remains 0.
